ringosc_fll_ctrl: RTL

// - Digital frequency-locked-loop controller closing the loop around the ring-oscillator VCO.
// - Consumes a prescaled VCO clock (ckdiv) and counts its edges over a fixed window of clk cycles.
// - Compares the count to a target and steps the code that sets vreg through an external DAC.
// - Asserts lock once the measured frequency stays within tolerance.

---
 rtl/ringosc_fll_pkg.sv | 16 +
 rtl/ringosc_fll_ctrl_edge_cnt.sv | 50 +++++
 rtl/ringosc_fll_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ringosc_fll_pkg.sv
// Shared types and default sizing for the ring-oscillator FLL controller.
package ringosc_fll_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEAS = 2'd1,
      CMP  = 2'd2,
      UPD  = 2'd3
   } fll_state_t;

   localparam int FLL_CW  = 16;
   localparam int FLL_WIN = 1024;
   localparam int ERR_W   = FLL_CW + 1;
   localparam int WCNT_W  = $clog2(FLL_WIN);

endpackage

// File: rtl/ringosc_fll_ctrl_edge_cnt.sv
// Synchronises the asynchronous prescaled VCO clock, detects its rising
// edges and counts them with saturation.
module fll_edge_cnt #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          cnt_en,
   input  logic          ckdiv,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic sync1_r;
   logic sync2_r;
   logic hist_r;
   logic rise_s;

   // two-flop synchroniser plus history flop for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         hist_r  <= 1'b0;
      end else begin
         sync1_r <= ckdiv;
         sync2_r <= sync1_r;
         hist_r  <= sync2_r;
      end
   end

   assign rise_s = sync2_r & ~hist_r;

   // saturating rising-edge counter
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (cnt_en && rise_s && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/ringosc_fll_ctrl.sv
// Frequency-locked-loop controller: measures ckdiv edges per window, steps
// the vreg DAC code toward the target count and reports lock.
module ringosc_fll_ctrl
   import ringosc_fll_pkg::*;
#(
   parameter int CW         = FLL_CW,
   parameter int DW         = 8,
   parameter int WIN        = FLL_WIN,
   parameter int CODE_INIT  = 128,
   parameter int TOL        = 2,
   parameter int LOCK_N     = 4,
   parameter int GAIN_SHIFT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CW-1:0] target,
   input  logic          ckdiv,
   output logic [DW-1:0] code,
   output logic          lock,
   output logic [CW-1:0] cnt_out,
   output logic          cnt_valid
);

   localparam int EW  = CW + 1;
   localparam int WW  = $clog2(WIN);
   localparam int SW  = DW + CW + 1;
   localparam int LCW = $clog2(LOCK_N + 1);

   localparam logic [WW-1:0]         WIN_LAST = WW'(WIN - 1);
   localparam logic [WW-1:0]         WIN_ONE  = {{(WW-1){1'b0}}, 1'b1};
   localparam logic signed [EW-1:0]  TOL_POS  = EW'(TOL);
   localparam logic signed [EW-1:0]  TOL_NEG  = -EW'(TOL);
   localparam logic signed [EW-1:0]  STEP_UP  = {{(EW-1){1'b0}}, 1'b1};
   localparam logic signed [SW-1:0]  CODE_MAX = SW'((1 << DW) - 1);
   localparam logic [LCW-1:0]        LOCK_MAX = LCW'(LOCK_N);
   localparam logic [LCW-1:0]        LOCK_PRE = LCW'(LOCK_N - 1);
   localparam logic [LCW-1:0]        LOCK_ONE = {{(LCW-1){1'b0}}, 1'b1};

   fll_state_t              state_r;
   fll_state_t              state_s;
   logic [WW-1:0]           win_r;
   logic [LCW-1:0]          lock_cnt_r;
   logic signed [EW-1:0]    err_r;
   logic [CW-1:0]           count_s;
   logic                    clr_s;
   logic                    cnt_en_s;
   logic signed [EW-1:0]    step_s;
   logic signed [SW-1:0]    sum_s;
   logic [DW-1:0]           code_s;
   logic                    in_band_s;

   fll_edge_cnt #(.CW(CW)) u_edge_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_s),
      .cnt_en (cnt_en_s),
      .ckdiv  (ckdiv),
      .count  (count_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next state and edge-counter control; en low aborts any window
   always_comb begin
      state_s  = state_r;
      clr_s    = 1'b0;
      cnt_en_s = 1'b0;
      if (!en) begin
         state_s = IDLE;
         clr_s   = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = MEAS;
               clr_s   = 1'b1;
            end
            MEAS: begin
               cnt_en_s = 1'b1;
               if (win_r == WIN_LAST) begin
                  state_s = CMP;
               end else begin
                  state_s = MEAS;
               end
            end
            CMP: begin
               state_s = UPD;
            end
            UPD: begin
               state_s = MEAS;
               clr_s   = 1'b1;
            end
            default: begin
               state_s = IDLE;
               clr_s   = 1'b1;
            end
         endcase
      end
   end

   // window counter runs only across consecutive MEAS cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         win_r <= '0;
      end else if ((state_r == MEAS) && (state_s == MEAS)) begin
         win_r <= win_r + WIN_ONE;
      end else begin
         win_r <= '0;
      end
   end

   // loop step: small errors still move the code by one LSB
   always_comb begin
      step_s    = err_r >>> GAIN_SHIFT;
      in_band_s = (err_r <= TOL_POS) && (err_r >= TOL_NEG);
      if (step_s == '0) begin
         if (err_r[EW-1]) begin
            step_s = '1;
         end else begin
            step_s = STEP_UP;
         end
      end else begin
         step_s = step_s;
      end
      sum_s = $signed({{(SW-DW){1'b0}}, code}) + $signed({{(SW-EW){step_s[EW-1]}}, step_s});
      if (sum_s[SW-1]) begin
         code_s = '0;
      end else if (sum_s > CODE_MAX) begin
         code_s = '1;
      end else begin
         code_s = sum_s[DW-1:0];
      end
   end

   // compare and update registers
   always_ff @(posedge clk) begin
      if (rst) begin
         code       <= DW'(CODE_INIT);
         lock       <= 1'b0;
         lock_cnt_r <= '0;
         cnt_out    <= '0;
         cnt_valid  <= 1'b0;
         err_r      <= '0;
      end else begin
         cnt_valid <= 1'b0;
         if (!en) begin
            lock       <= 1'b0;
            lock_cnt_r <= '0;
         end else if (state_r == CMP) begin
            cnt_out   <= count_s;
            cnt_valid <= 1'b1;
            err_r     <= $signed({1'b0, target} - {1'b0, count_s});
         end else if (state_r == UPD) begin
            if (in_band_s) begin
               if (lock_cnt_r != LOCK_MAX) begin
                  lock_cnt_r <= lock_cnt_r + LOCK_ONE;
               end else begin
                  lock_cnt_r <= lock_cnt_r;
               end
               lock <= (lock_cnt_r >= LOCK_PRE);
            end else begin
               code       <= code_s;
               lock_cnt_r <= '0;
               lock       <= 1'b0;
            end
         end else begin
            lock <= lock;
         end
      end
   end

endmodule
